seg_display_arbiter: RTL
========================

Name: seg_display_arbiter

Overview:
- Shares the single 4-digit seven-segment display value among NUM_REQ independent requesters (debug counters, status codes, error values).
- Grants the display round-robin with a guaranteed minimum dwell time per grant, so each value stays readable.
- Drives the 16-bit value consumed by the display multiplexer/decoder, plus ownership status for LEDs.

Parameters:
- NUM_REQ, 4, number of requesters; legal 2..8.
- HOLD_CYCLES, 100000000, minimum display dwell per grant in clk cycles (1 s at 100 MHz); legal >= 1.
- IDX_W, $clog2(NUM_REQ), width of the owner index (derived, do not override).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  bit i: requester i offers a value
- req_data  in  16*NUM_REQ  slice [16*i+15:16*i] = requester i value (binary, displayed as decimal modulo 10000 downstream)
- req_ready  out  NUM_REQ  bit i: requester i value accepted this cycle (combinational)
- data_seg  out  16  value to display
- owner  out  IDX_W  index of the requester currently shown
- display_valid  out  1  high once any value has been accepted since reset
- hold_active  out  1  high while the dwell timer runs

Behaviour:
- Reset (already decided): reset rst, synchronous, active-high; clock clk. On reset: data_seg=0, owner=0, display_valid=0, hold_active=0, state=IDLE, timer=0, round-robin pointer=NUM_REQ-1 (requester 0 has top priority first).
- Handshake: transfer occurs at a posedge where req_valid[i] & req_ready[i]. Requesters hold valid and data stable until accepted. At most one req_ready bit is high in any cycle. req_ready never depends on req_data.
- States: IDLE and HOLD.
- IDLE (also the final HOLD cycle, see below) is an arbitration cycle:
  - Search for the first valid requester starting at pointer+1 and wrapping modulo NUM_REQ.
  - On a winner w: req_ready[w]=1. Next cycle: data_seg=req_data[w], owner=w, pointer=w, display_valid=1, state=HOLD, timer=HOLD_CYCLES-1, hold_active=1.
  - If no requester is valid: stay in IDLE; data_seg and owner keep their last values.
- HOLD:
  - Timer decrements each cycle.
  - While timer!=0: only the owner may update. If req_valid[owner], then req_ready[owner]=1 and data_seg updates next cycle. The timer is not restarted. All other requesters see ready=0.
  - Cycle with timer==0: this is an arbitration cycle as in IDLE, and the owner is naturally lowest priority because the search starts at owner+1. With a winner, HOLD re-enters with a fresh timer (the owner itself can win if it is the only valid requester). With no winner, state=IDLE and hold_active=0 next cycle.
- Timing: with the grant cycle at T, data_seg changes at T+1, hold_active is high for T+1..T+HOLD_CYCLES, and the earliest next grant to another requester is cycle T+HOLD_CYCLES (data visible at T+HOLD_CYCLES+1). Each granted value is therefore displayed for at least HOLD_CYCLES cycles.
- HOLD_CYCLES=1: every cycle is an arbitration cycle, giving pure round-robin.
- Fairness: a continuously valid requester is granted within (NUM_REQ-1)*HOLD_CYCLES+1 cycles.
- Timer width is 32 bits with no overflow. data_seg is passed through unmodified; no arithmetic on data.
- Reset asserted mid-HOLD: all state returns to reset values on that edge; any pending handshake is dropped (req_ready=0 during reset).

Test Plan (NUM_REQ=4, HOLD_CYCLES=4):
- Reset, then req_valid=0000 for 10 cycles -> req_ready=0000, data_seg=0, display_valid=0, hold_active=0 throughout.
- Only req 2 valid with 16'd1234 from cycle 0 -> req_ready[2] pulses in cycle 0; data_seg=1234, owner=2, display_valid=1 from cycle 1; hold_active high cycles 1-4; req 2 re-granted at cycle 4.
- Reqs 0,1,3 all held valid with 11/22/33 -> grants 0@t0, 1@t4, 3@t8, 0@t12; data_seg follows 11, 22, 33, 11 one cycle after each grant.
- Owner 1 granted 500 at t0, drives 501 valid at t2; req 3 valid from t1 -> req_ready[1] at t2, data_seg=501 at t3, req 3 granted at t4 (timer not restarted), data_seg=req 3 value at t5.
- rst asserted at t2 of a HOLD with req 0 owning 777 -> at t3 data_seg=0, owner=0, hold_active=0, display_valid=0; after release the pointer restarts so req 0 has priority.
- All requesters drop valid before expiry -> state IDLE after timer==0 cycle, hold_active=0, data_seg retains last value, display_valid stays 1.

Source files
------------

// File: rtl/seg_display_arbiter_if.sv
// ---------------------------------------------------------------------------
// seg_display_arbiter_if
// Bundle between the display requesters and the display arbiter.
//   req_valid     [NUM_REQ]     requester i offers a value
//   req_data      [16*NUM_REQ]  slice [16*i+15:16*i] is requester i value
//   req_ready     [NUM_REQ]     requester i value accepted this cycle
//   data_seg      [16]          value handed to the display mux/decoder
//   owner         [IDX_W]       requester currently shown
//   display_valid               a value has been accepted since reset
//   hold_active                 dwell timer running
// master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface seg_display_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]    req_valid;
   logic [16*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]    req_ready;
   logic [15:0]           data_seg;
   logic [IDX_W-1:0]      owner;
   logic                  display_valid;
   logic                  hold_active;

   modport master (
      output req_valid, req_data,
      input  req_ready, data_seg, owner, display_valid, hold_active
   );

   modport slave (
      input  req_valid, req_data,
      output req_ready, data_seg, owner, display_valid, hold_active
   );
endinterface

// File: rtl/seg_display_arbiter.sv
// ---------------------------------------------------------------------------
// seg_display_arbiter
// Shares one 4-digit seven-segment display value among NUM_REQ requesters.
// Grants are round-robin; every grant is shown for at least HOLD_CYCLES
// clocks. During the dwell only the current owner may refresh its value.
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   bus  seg_display_arbiter_if.slave (request handshake + display outputs)
// ---------------------------------------------------------------------------
module seg_display_arbiter #(
   parameter int  NUM_REQ     = 4,
   parameter int  HOLD_CYCLES = 100000000,
   localparam int IDX_W       = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   seg_display_arbiter_if.slave   bus
);

   typedef enum logic {ST_IDLE, ST_HOLD} state_t;

   localparam logic [31:0] TIMER_LOAD = 32'(HOLD_CYCLES - 1);

   state_t             r_state, w_state_nxt;
   logic [31:0]        r_timer, w_timer_nxt;
   logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
   logic [IDX_W-1:0]   r_owner, w_owner_nxt;
   logic [15:0]        r_data, w_data_nxt;
   logic               r_dvld, w_dvld_nxt;

   logic               w_arb;
   logic               w_found;
   logic [IDX_W-1:0]   w_win;
   logic [NUM_REQ-1:0] w_ready;

   // IDLE cycles and the last HOLD cycle are both arbitration cycles.
   assign w_arb = (r_state == ST_IDLE) || (r_timer == 32'd0);

   // Round-robin search starting just after the last granted requester,
   // so the previous owner naturally ends up with the lowest priority.
   always_comb begin : p_search
      int v_idx;
      w_found = 1'b0;
      w_win   = r_ptr;
      v_idx   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         v_idx = (int'(r_ptr) + k) % NUM_REQ;
         if (!w_found && bus.req_valid[v_idx]) begin
            w_found = 1'b1;
            w_win   = IDX_W'(v_idx);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_ptr_nxt   = r_ptr;
      w_owner_nxt = r_owner;
      w_data_nxt  = r_data;
      w_dvld_nxt  = r_dvld;
      w_ready     = '0;

      if (w_arb) begin
         if (w_found) begin
            w_ready[w_win] = 1'b1;
            w_state_nxt    = ST_HOLD;
            w_timer_nxt    = TIMER_LOAD;
            w_data_nxt     = bus.req_data[16*int'(w_win) +: 16];
            w_owner_nxt    = w_win;
            w_ptr_nxt      = w_win;
            w_dvld_nxt     = 1'b1;
         end else begin
            w_state_nxt    = ST_IDLE;
         end
      end else begin
         // Dwell in progress: the owner may refresh, the timer keeps running.
         w_timer_nxt = r_timer - 32'd1;
         if (bus.req_valid[r_owner]) begin
            w_ready[r_owner] = 1'b1;
            w_data_nxt       = bus.req_data[16*int'(r_owner) +: 16];
         end
      end

      // No handshake may complete while reset is held.
      if (rst) begin
         w_ready = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_timer <= 32'd0;
         r_ptr   <= IDX_W'(NUM_REQ - 1);
         r_owner <= '0;
         r_data  <= 16'd0;
         r_dvld  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_ptr   <= w_ptr_nxt;
         r_owner <= w_owner_nxt;
         r_data  <= w_data_nxt;
         r_dvld  <= w_dvld_nxt;
      end
   end

   assign bus.req_ready     = w_ready;
   assign bus.data_seg      = r_data;
   assign bus.owner         = r_owner;
   assign bus.display_valid = r_dvld;
   assign bus.hold_active   = (r_state == ST_HOLD);

endmodule
